idma_desc64_r_assemble: RTL and testbench
=========================================

# idma_desc64_r_assemble

Consumes the AXI R beats returned for descriptor fetches, assembles them into one 256-bit descriptor, and presents it on a valid/ready stream to the iDMA request-conversion stage. Sits directly downstream of the descriptor AR generator. Extracts the descriptor's next-pointer field early and feeds it back as the next-address/valid pair the AR generator uses to chain fetches.

## Interface
- DataWidth, 64: AXI data width; must be 64, 128 or 256.
- descriptor_t, logic: packed 256-bit descriptor: word0 {flags[31:0], length[31:0]}, word1 next, word2 src, word3 dst.
- axi_r_chan_t, logic: AXI R channel struct (data, resp, last, id).
- addr_t, logic: 64-bit address type.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- axi_r_chan_i  in  axi_r_chan_t  R beat payload.
- axi_r_valid_i  in  1  R valid.
- axi_r_ready_o  out  1  R ready.
- descriptor_o  out  descriptor_t  assembled descriptor.
- descriptor_valid_o  out  1  descriptor valid.
- descriptor_ready_i  in  1  descriptor ready.
- descriptor_error_o  out  1  qualifies descriptor_o: some beat had resp[1]=1.
- next_address_o  out  addr_t  next pointer of descriptor being fetched.
- next_address_valid_o  out  1  one-cycle pulse per descriptor.
- busy_o  out  1  beats collected or descriptor held.

## Operation
- BeatsPerDesc = 256/DataWidth (4, 2, 1); beat counter width max(1, $clog2(BeatsPerDesc)).
- Beat i fills descriptor bits [i*DataWidth +: DataWidth] of the collect register; resp[1] on any beat sets sticky err_q.
- States: COLLECT (axi_r_ready_o=1), WAIT_OUT (axi_r_ready_o=0).
- COLLECT, final beat accepted: if output register empty, or full and handshaking this cycle, move descriptor+err into output register, clear counter and err_q, stay COLLECT; else go WAIT_OUT.
- WAIT_OUT: transfer when output register empties or handshakes; return to COLLECT.
- Next-pointer beat NextBeat = 64/DataWidth for DataWidth=64 (beat 1), else beat 0. On its acceptance, register word1 into next_address_o and pulse next_address_valid_o next cycle.
- If that beat, or an earlier beat of the descriptor, has resp[1]=1, next_address_o = '1 (end-of-chain) so the AR generator falls back to its queue.
- Output register: one entry; valid held until descriptor_ready_i; payload stable while valid & !ready.
- busy_o = (counter != 0) | (state == WAIT_OUT) | descriptor_valid_o.
- R id is ignored; all beats are descriptor beats.

## Timing
- Reset: axi_r_ready_o=1 (COLLECT), descriptor_valid_o=0, descriptor_error_o=0, descriptor_o='0, next_address_o='1, next_address_valid_o=0, busy_o=0, counter=0.
- Latency: final beat accepted in cycle N -> descriptor_valid_o=1 in N+1 when output register is free.
- Next-pointer beat accepted in cycle M -> next_address_valid_o=1 in M+1 only.
- Simultaneous final beat and output handshake: no bubble; new descriptor valid next cycle.
- Back-to-back descriptors at full R rate are sustained if descriptor_ready_i stays 1.
- Reset mid-descriptor discards partial beats; no descriptor or pulse is emitted.

## Configuration
- IDMA_DESC64_R_LAST_CHECK_EN defined: rlast is compared with (counter == BeatsPerDesc-1). A mismatch sets err_q for the current descriptor. An early rlast also closes the descriptor; unfilled words are '0.
- Not defined: rlast is ignored and the counter alone delimits descriptors.

## Structure
- Package idma_desc64_pkg holds descriptor_t layout, word offsets (FlagsLenWord=0, NextWord=1, SrcWord=2, DstWord=3) and the end-of-chain constant '1.
- The output stage is one instance of common_cells stream_register-style sub-module idma_desc64_r_outreg: one entry, valid/ready, with payload {descriptor_t, error}.
- FSM, counter and collect register are in the top module.

## Test plan
- DataWidth=64, four OKAY beats, words A,0x1000,S,D, ready=1 -> descriptor {A,0x1000,S,D} valid one cycle after beat 3; next_address_o=0x1000 pulses the cycle after beat 1.
- Second descriptor streamed while descriptor_ready_i=0 -> axi_r_ready_o drops after its beat 3 (WAIT_OUT); first descriptor held stable; after ready=1, second descriptor valid next cycle.
- Beat 0 resp=SLVERR -> next_address_o='1 pulse after beat 1; descriptor_error_o=1 with the descriptor; next descriptor error-free.
- DataWidth=256, single beat -> next pulse and descriptor_valid_o both in the following cycle.
- With IDMA_DESC64_R_LAST_CHECK_EN, rlast on beat 1 of 4 -> descriptor emitted with words 2,3 = 0 and descriptor_error_o=1; without the macro, the descriptor completes after 4 beats, error=0.
- rst_ni asserted after 2 of 4 beats -> no descriptor, no pulse; a following full descriptor assembles correctly from beat 0.

Source files
------------

// File: rtl/idma_desc64_pkg.sv
// Shared types and constants for the iDMA 64-bit descriptor fetch path.
// Holds the 256-bit descriptor layout, word offsets and the end-of-chain pointer value.
package idma_desc64_pkg;

    typedef logic [63:0] addr_t;

    // word3 dst, word2 src, word1 next, word0 {flags, length}
    typedef struct packed {
        addr_t       dst;
        addr_t       src;
        addr_t       next;
        logic [31:0] flags;
        logic [31:0] length;
    } descriptor_t;

    localparam int unsigned DescWidth    = 256;
    localparam int unsigned WordWidth    = 64;
    localparam int unsigned FlagsLenWord = 0;
    localparam int unsigned NextWord     = 1;
    localparam int unsigned SrcWord      = 2;
    localparam int unsigned DstWord      = 3;

    localparam addr_t EndOfChain = '1;

    // Default R channel for a 64-bit data bus
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_chan64_t;

    typedef enum logic {
        ST_COLLECT  = 1'b0,
        ST_WAIT_OUT = 1'b1
    } state_e;

endpackage

// File: rtl/idma_desc64_r_outreg.sv
// One-entry valid/ready output register for the assembled descriptor and its error flag.
// Payload only loads when the slot is free or draining, so it stays stable under backpressure.
module idma_desc64_r_outreg #(
    parameter int unsigned Width = 257
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    logic             r_valid;
    logic [Width-1:0] r_data;

    assign ready_o = !r_valid || ready_i;
    assign valid_o = r_valid;
    assign data_o  = r_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (valid_i && ready_o) begin
            r_valid <= 1'b1;
            r_data  <= data_i;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/idma_desc64_r_assemble.sv
// Assembles AXI R beats into 256-bit descriptors and feeds the next pointer back to the AR side.
// Optional macro IDMA_DESC64_R_LAST_CHECK_EN: check rlast against the beat count and close on early rlast.
module idma_desc64_r_assemble
    import idma_desc64_pkg::*;
#(
    parameter int unsigned DataWidth    = 64,
    parameter type         axi_r_chan_t = axi_r_chan64_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  axi_r_chan_t axi_r_chan_i,
    input  logic        axi_r_valid_i,
    output logic        axi_r_ready_o,
    output descriptor_t descriptor_o,
    output logic        descriptor_valid_o,
    input  logic        descriptor_ready_i,
    output logic        descriptor_error_o,
    output addr_t       next_address_o,
    output logic        next_address_valid_o,
    output logic        busy_o
);

    localparam int unsigned BeatsPerDesc = DescWidth / DataWidth;
    localparam int unsigned CntW         = (BeatsPerDesc > 1) ? $clog2(BeatsPerDesc) : 1;
    localparam int unsigned NextBeat     = (DataWidth == 64) ? 1 : 0;
    localparam logic [CntW-1:0] LastCnt  = CntW'(BeatsPerDesc - 1);
    localparam logic [CntW-1:0] NextCnt  = CntW'(NextBeat);

    state_e                 r_state, w_state_d;
    logic [CntW-1:0]        r_cnt;
    logic [DescWidth-1:0]   r_collect;
    logic                   r_err;
    addr_t                  r_next_addr;
    logic                   r_next_vld;

    logic                   w_accept;
    logic                   w_close;
    logic                   w_beat_err;
    logic                   w_next_beat;
    logic [DescWidth-1:0]   w_merged;
    logic                   w_out_valid;
    logic                   w_out_ready;
    logic [DescWidth-1:0]   w_out_desc;
    logic                   w_out_err;
    logic [DescWidth:0]     w_out_q;
    logic                   w_unused;

    // id and resp[0] carry no meaning here
    assign w_unused = ^axi_r_chan_i;

    assign w_accept    = axi_r_valid_i && axi_r_ready_o;
    assign w_next_beat = (r_cnt == NextCnt);

`ifdef IDMA_DESC64_R_LAST_CHECK_EN
    assign w_close    = (r_cnt == LastCnt) || axi_r_chan_i.last;
    assign w_beat_err = axi_r_chan_i.resp[1] || (axi_r_chan_i.last != (r_cnt == LastCnt));
`else
    assign w_close    = (r_cnt == LastCnt);
    assign w_beat_err = axi_r_chan_i.resp[1];
`endif

    // Collect register with the current beat dropped into its slot; later slots are still zero
    always_comb begin
        w_merged = r_collect;
        for (int b = 0; b < BeatsPerDesc; b++) begin
            if (r_cnt == CntW'(b)) w_merged[b*DataWidth +: DataWidth] = axi_r_chan_i.data;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        axi_r_ready_o = 1'b0;
        w_out_valid   = 1'b0;
        w_out_desc    = w_merged;
        w_out_err     = r_err || w_beat_err;
        case (r_state)
            ST_COLLECT: begin
                axi_r_ready_o = 1'b1;
                if (axi_r_valid_i && w_close) begin
                    w_out_valid = 1'b1;
                    if (!w_out_ready) w_state_d = ST_WAIT_OUT;
                end
            end
            ST_WAIT_OUT: begin
                w_out_valid = 1'b1;
                w_out_desc  = r_collect;
                w_out_err   = r_err;
                if (w_out_ready) w_state_d = ST_COLLECT;
            end
            default: w_state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_COLLECT;
            r_cnt     <= '0;
            r_collect <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                if (w_close) begin
                    r_cnt <= '0;
                    if (w_out_ready) begin
                        r_collect <= '0;
                        r_err     <= 1'b0;
                    end else begin
                        r_collect <= w_merged;
                        r_err     <= r_err || w_beat_err;
                    end
                end else begin
                    r_cnt     <= r_cnt + 1'b1;
                    r_collect <= w_merged;
                    r_err     <= r_err || w_beat_err;
                end
            end else if ((r_state == ST_WAIT_OUT) && w_out_ready) begin
                r_collect <= '0;
                r_err     <= 1'b0;
            end
        end
    end

    // A faulted fetch gives the AR generator end-of-chain so it falls back to its queue
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_next_addr <= EndOfChain;
            r_next_vld  <= 1'b0;
        end else begin
            r_next_vld <= w_accept && w_next_beat;
            if (w_accept && w_next_beat) begin
                r_next_addr <= (r_err || axi_r_chan_i.resp[1]) ? EndOfChain
                                                               : w_merged[NextWord*WordWidth +: WordWidth];
            end
        end
    end

    idma_desc64_r_outreg #(
        .Width (DescWidth + 1)
    ) u_outreg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (w_out_valid),
        .ready_o (w_out_ready),
        .data_i  ({w_out_desc, w_out_err}),
        .valid_o (descriptor_valid_o),
        .ready_i (descriptor_ready_i),
        .data_o  (w_out_q)
    );

    assign descriptor_o         = w_out_q[DescWidth:1];
    assign descriptor_error_o   = w_out_q[0];
    assign next_address_o       = r_next_addr;
    assign next_address_valid_o = r_next_vld;
    assign busy_o               = (r_cnt != '0) || (r_state == ST_WAIT_OUT) || descriptor_valid_o;

endmodule

// File: tb/tb_idma_desc64_r_assemble.sv
// Bench for idma_desc64_r_assemble: directed steps on 64- and 256-bit instances plus a random
// 64-bit run checked against a descriptor/next-pointer queue model.
`timescale 1ns/1ps
module tb_idma_desc64_r_assemble;
    import idma_desc64_pkg::*;

    typedef axi_r_chan64_t r64_t;
    typedef struct packed {
        logic [3:0]   id;
        logic [255:0] data;
        logic [1:0]   resp;
        logic         last;
    } r256_t;

    localparam logic [63:0] EOC = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    r64_t        r64;
    logic        v64, rdy64, dv64, dr64, de64, nav64, busy64;
    descriptor_t desc64;
    addr_t       na64;

    r256_t       r256;
    logic        v256, rdy256, dv256, dr256, de256, nav256, busy256;
    descriptor_t desc256;
    addr_t       na256;

    idma_desc64_r_assemble #(.DataWidth(64), .axi_r_chan_t(r64_t)) u64 (
        .clk_i(clk), .rst_ni(rst_n), .axi_r_chan_i(r64), .axi_r_valid_i(v64), .axi_r_ready_o(rdy64),
        .descriptor_o(desc64), .descriptor_valid_o(dv64), .descriptor_ready_i(dr64),
        .descriptor_error_o(de64), .next_address_o(na64), .next_address_valid_o(nav64), .busy_o(busy64)
    );

    idma_desc64_r_assemble #(.DataWidth(256), .axi_r_chan_t(r256_t)) u256 (
        .clk_i(clk), .rst_ni(rst_n), .axi_r_chan_i(r256), .axi_r_valid_i(v256), .axi_r_ready_o(rdy256),
        .descriptor_o(desc256), .descriptor_valid_o(dv256), .descriptor_ready_i(dr256),
        .descriptor_error_o(de256), .next_address_o(na256), .next_address_valid_o(nav256), .busy_o(busy256)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [63:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Drive one 64-bit beat, wait (bounded) until it is taken; returns at accept edge + 1
    task automatic send64(input logic [63:0] d, input logic [1:0] rs, input logic l);
        logic acc;
        r64.id = 4'($urandom_range(0, 15));
        r64.data = d; r64.resp = rs; r64.last = l;
        v64 = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = rdy64;
            @(posedge clk); #1;
        end
        v64 = 1'b0;
        chk("r64_accept", acc, 1'b1);
    endtask

    task automatic send256(input logic [255:0] d, input logic [1:0] rs);
        r256.id = 4'($urandom_range(0, 15));
        r256.data = d; r256.resp = rs; r256.last = 1'b1;
        v256 = 1'b1;
        @(posedge clk); #1;
        v256 = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // Scoreboard for the random phase
    logic [256:0] exp_desc[$];
    logic [63:0]  exp_na[$];
    logic         mon_en = 1'b0;
    logic         hold_prev = 1'b0;
    logic [255:0] prev_desc;

    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_prev) begin
                chk("hold_valid", dv64, 1'b1);
                chk("hold_stable", desc64, prev_desc);
            end
            if (dv64 && dr64) begin
                chk("rnd_desc_expected", exp_desc.size() != 0, 1'b1);
                if (exp_desc.size() != 0) chk("rnd_desc", {desc64, de64}, exp_desc.pop_front());
            end
            if (nav64) begin
                chk("rnd_na_expected", exp_na.size() != 0, 1'b1);
                if (exp_na.size() != 0) chk("rnd_na", na64, exp_na.pop_front());
            end
            hold_prev = dv64 && !dr64;
            prev_desc = desc64;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w[4];
        logic [63:0] x[4];
        logic [63:0] y[4];
        logic        drv_done;

        r64 = '0; v64 = 1'b0; dr64 = 1'b1;
        r256 = '0; v256 = 1'b0; dr256 = 1'b1;
        #3 rst_n = 1'b0;
        #10;
        chk("rst_rready", rdy64, 1'b1);
        chk("rst_dvalid", dv64, 1'b0);
        chk("rst_derr", de64, 1'b0);
        chk("rst_desc", desc64, '0);
        chk("rst_na", na64, EOC);
        chk("rst_nav", nav64, 1'b0);
        chk("rst_busy", busy64, 1'b0);
        chk("rst_na256", na256, EOC);
        chk("rst_dvalid256", dv256, 1'b0);
        #4 rst_n = 1'b1;
        cyc();

        // Basic four-beat descriptor, next pointer 0x1000
        w[0] = rnd64(); w[1] = 64'h1000; w[2] = rnd64(); w[3] = rnd64();
        send64(w[0], 2'b00, 1'b0);
        chk("t1_nav_b0", nav64, 1'b0);
        chk("t1_busy_b0", busy64, 1'b1);
        send64(w[1], 2'b00, 1'b0);
        chk("t1_nav_b1", nav64, 1'b1);
        chk("t1_na", na64, 64'h1000);
        send64(w[2], 2'b00, 1'b0);
        chk("t1_nav_b2", nav64, 1'b0);
        chk("t1_dv_b2", dv64, 1'b0);
        send64(w[3], 2'b00, 1'b1);
        chk("t1_dv", dv64, 1'b1);
        chk("t1_desc", {desc64, de64}, {mk(w[0], w[1], w[2], w[3]), 1'b0});
        cyc();
        chk("t1_dv_drop", dv64, 1'b0);
        chk("t1_idle", busy64, 1'b0);

        // Backpressure: second descriptor parks in WAIT_OUT
        dr64 = 1'b0;
        foreach (x[i]) x[i] = rnd64();
        foreach (y[i]) y[i] = rnd64();
        for (int i = 0; i < 4; i++) send64(x[i], 2'b00, i == 3);
        chk("t2_x_valid", {dv64, desc64}, {1'b1, mk(x[0], x[1], x[2], x[3])});
        for (int i = 0; i < 3; i++) send64(y[i], 2'b00, 1'b0);
        r64.data = y[3]; r64.resp = 2'b00; r64.last = 1'b1; v64 = 1'b1;
        cyc();
        v64 = 1'b0;
        chk("t2_rready_low", rdy64, 1'b0);
        chk("t2_busy", busy64, 1'b1);
        chk("t2_x_held", {dv64, desc64}, {1'b1, mk(x[0], x[1], x[2], x[3])});
        cyc();
        chk("t2_rready_low2", rdy64, 1'b0);
        chk("t2_x_held2", {dv64, desc64}, {1'b1, mk(x[0], x[1], x[2], x[3])});
        dr64 = 1'b1;
        cyc();
        chk("t2_y_valid", {dv64, desc64, de64}, {1'b1, mk(y[0], y[1], y[2], y[3]), 1'b0});
        chk("t2_rready_back", rdy64, 1'b1);
        cyc();
        chk("t2_drain", dv64, 1'b0);

        // SLVERR on beat 0: end-of-chain pointer and error flag, next descriptor clean
        foreach (w[i]) w[i] = rnd64();
        send64(w[0], 2'b10, 1'b0);
        send64(w[1], 2'b00, 1'b0);
        chk("t3_nav", nav64, 1'b1);
        chk("t3_na_eoc", na64, EOC);
        send64(w[2], 2'b00, 1'b0);
        send64(w[3], 2'b00, 1'b1);
        chk("t3_err_desc", {dv64, desc64, de64}, {1'b1, mk(w[0], w[1], w[2], w[3]), 1'b1});
        foreach (w[i]) w[i] = rnd64();
        for (int i = 0; i < 4; i++) begin
            send64(w[i], 2'b00, i == 3);
            if (i == 1) chk("t3_na_clean", {nav64, na64}, {1'b1, w[1]});
        end
        chk("t3_clean_desc", {dv64, desc64, de64}, {1'b1, mk(w[0], w[1], w[2], w[3]), 1'b0});

        // Full-rate back-to-back with ready held high
        foreach (x[i]) x[i] = rnd64();
        foreach (y[i]) y[i] = rnd64();
        for (int i = 0; i < 4; i++) send64(x[i], 2'b00, i == 3);
        chk("t4_first", {dv64, desc64}, {1'b1, mk(x[0], x[1], x[2], x[3])});
        for (int i = 0; i < 4; i++) send64(y[i], 2'b00, i == 3);
        chk("t4_second", {dv64, desc64}, {1'b1, mk(y[0], y[1], y[2], y[3])});
        cyc();

        // rlast on beat 1
        foreach (w[i]) w[i] = rnd64();
        send64(w[0], 2'b00, 1'b0);
        send64(w[1], 2'b00, 1'b1);
`ifdef IDMA_DESC64_R_LAST_CHECK_EN
        chk("t5_early_close", {dv64, desc64, de64}, {1'b1, mk(w[0], w[1], 64'h0, 64'h0), 1'b1});
        cyc();
`else
        chk("t5_no_close", dv64, 1'b0);
        send64(w[2], 2'b00, 1'b0);
        send64(w[3], 2'b00, 1'b1);
        chk("t5_full", {dv64, desc64, de64}, {1'b1, mk(w[0], w[1], w[2], w[3]), 1'b0});
        cyc();
`endif
        chk("t5_idle", busy64, 1'b0);

        // Reset mid-descriptor discards the partial beats
        foreach (w[i]) w[i] = rnd64();
        send64(w[0], 2'b00, 1'b0);
        send64(w[1], 2'b00, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", {dv64, nav64, busy64, na64}, {3'b000, EOC});
        #2 rst_n = 1'b1;
        cyc();
        chk("t6_quiet", {dv64, nav64, busy64}, 3'b000);
        foreach (w[i]) w[i] = rnd64();
        for (int i = 0; i < 4; i++) begin
            send64(w[i], 2'b00, i == 3);
            if (i == 1) chk("t6_na", {nav64, na64}, {1'b1, w[1]});
        end
        chk("t6_desc", {dv64, desc64, de64}, {1'b1, mk(w[0], w[1], w[2], w[3]), 1'b0});
        cyc();

        // 256-bit bus: single beat, pointer pulse and descriptor in the same cycle
        for (int k = 0; k < 3; k++) begin
            foreach (w[i]) w[i] = rnd64();
            send256(mk(w[0], w[1], w[2], w[3]), (k == 1) ? 2'b10 : 2'b01);
            chk("t7_nav", {nav256, na256}, {1'b1, (k == 1) ? EOC : w[1]});
            chk("t7_desc", {dv256, desc256, de256}, {1'b1, mk(w[0], w[1], w[2], w[3]), k == 1});
        end
        cyc();
        chk("t7_idle", {dv256, nav256, busy256}, 3'b000);

        // Random traffic against the queue model, random gaps and backpressure
        mon_en = 1'b1;
        drv_done = 1'b0;
        fork
            begin
                for (int d = 0; d < 24; d++) begin
                    logic [1:0] rs[4];
                    foreach (w[i]) w[i] = rnd64();
                    foreach (rs[i]) rs[i] = {($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1))};
                    exp_desc.push_back({mk(w[0], w[1], w[2], w[3]),
                                        rs[0][1] | rs[1][1] | rs[2][1] | rs[3][1]});
                    exp_na.push_back((rs[0][1] | rs[1][1]) ? EOC : w[1]);
                    for (int b = 0; b < 4; b++) begin
                        repeat ($urandom_range(0, 2)) cyc();
                        send64(w[b], rs[b], b == 3);
                    end
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    dr64 = ($urandom_range(0, 3) != 0);
                    cyc();
                end
                dr64 = 1'b1;
            end
        join
        for (int t = 0; t < 500 && (exp_desc.size() != 0 || exp_na.size() != 0); t++) cyc();
        chk("rnd_desc_drained", exp_desc.size(), 0);
        chk("rnd_na_drained", exp_na.size(), 0);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
